pc_update_unit: RTL and testbench
=================================

PC_UPDATE_UNIT -- requirements
Module: pc_update_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, is the PC value loaded at reset.
REQ-002 Port CLK, input, 1, the single clock; all state updates on its rising edge.
REQ-003 Port RST, input, 1, synchronous active-low reset, sampled on the rising edge of CLK.
REQ-004 Port PCPlus4, input, 32, sequential next-PC candidate.
REQ-005 Port branchPC, input, 32, branch target candidate.
REQ-006 Port jmpPC, input, 32, jump target candidate.
REQ-007 Port regPC, input, 32, register-indirect (jr) target candidate.
REQ-008 Port PCSrc, input, 2, target select: 00 PCPlus4, 01 branch, 10 jump, 11 register.
REQ-009 Port branchTaken, input, 1, qualifies PCSrc=01; when 0, PCPlus4 is used instead.
REQ-010 Port PCWrite, input, 1, update enable; 0 = stall and hold PC.
REQ-011 Port halt, input, 1, halt request from decode.
REQ-012 Port imemReady, input, 1, instruction memory accepts the fetch at curPC this cycle.
REQ-013 Port curPC, output, 32, current PC driven to instruction memory and to the PC calculation logic.
REQ-014 Port fetchValid, output, 1, curPC is a valid fetch request.
REQ-015 Port halted, output, 1, block is in HALT.
REQ-016 Port misaligned, output, 1, block is in FAULT due to a misaligned target.

Function
REQ-017 States SHALL be RUN, WAIT, HALT and FAULT.
REQ-018 nextPC SHALL be the candidate selected by PCSrc and branchTaken per REQ-008/009, computed combinationally.
REQ-019 In RUN, when PCWrite=1, imemReady=1, halt=0 and nextPC[1:0]=00, curPC SHALL load nextPC on the next edge and the state SHALL stay RUN.
REQ-020 In RUN, when imemReady=0, curPC SHALL hold and the state SHALL go to WAIT; fetchValid SHALL stay 1.
REQ-021 In WAIT, curPC SHALL hold until imemReady=1; the next edge SHALL then apply the REQ-019 update and return the state to RUN.
REQ-022 When PCWrite=0 in RUN or WAIT, curPC SHALL hold regardless of imemReady, and the state SHALL be unchanged.
REQ-023 When halt=1 in RUN or WAIT, the state SHALL go to HALT and curPC SHALL hold.
REQ-024 halt SHALL take priority over PCWrite, imemReady and the misalignment check.
REQ-025 HALT and FAULT SHALL be sticky, with fetchValid=0 in both; only reset exits them.
REQ-026 When an update would occur and nextPC[1:0]!=00, curPC SHALL hold, the state SHALL go to FAULT, and misaligned SHALL assert.
REQ-027 The misalignment check SHALL be evaluated only when an update would occur (PCWrite=1, imemReady=1).
REQ-028 Outputs: halted=1 exactly in HALT; misaligned=1 exactly in FAULT; fetchValid=1 exactly in RUN or WAIT.
REQ-029 The update latency from the select inputs to curPC SHALL be exactly one cycle.
REQ-030 Arithmetic: the block performs no addition; a wrap from 32'hFFFF_FFFC to 0 via PCPlus4 SHALL be accepted as a normal update.

Reset
REQ-031 When RST=0 at an edge, curPC SHALL become RESET_PC, the state RUN, fetchValid 1, halted 0 and misaligned 0.
REQ-032 Reset SHALL override all other inputs, including mid-WAIT, in HALT and in FAULT.

Structure
REQ-033 The state encoding and the PCSrc codes SHALL be defined as constants in a shared CPU definitions package.
REQ-034 The next-PC selector SHALL be a sub-module named pc_next_mux; the FSM and the PC register SHALL reside in pc_update_unit.

Verification
REQ-035 Reset sequencing: RST=0 for 1 cycle, then RST=1, PCSrc=00, PCPlus4 tracking curPC+4, PCWrite=1, imemReady=1 -> curPC = 0, 4, 8 on successive cycles.
REQ-036 Branch qualification: curPC=0x10, PCSrc=01, branchPC=0x40, branchTaken=0 -> curPC=0x14; repeated with branchTaken=1 -> curPC=0x40.
REQ-037 Wait and stall hold: imemReady=0 for 3 cycles at curPC=0x20 -> curPC holds 0x20 and the state is WAIT; repeated with PCWrite=0 -> curPC also holds.
REQ-038 Register jump misalignment: PCSrc=11, regPC=0x102 -> misaligned=1, curPC unchanged, fetchValid=0, and the state persists until RST=0.
REQ-039 Halt priority: halt=1 together with PCSrc=10, jmpPC=0x80 -> halted=1 and curPC not 0x80; a reset then gives curPC=RESET_PC and halted=0.
REQ-040 Wrap-around: curPC=0xFFFF_FFFC with PCPlus4=0 -> curPC=0 and no fault.

Source files
------------

// File: rtl/pc_update_unit_pkg.sv
// ============================================================================
// Module   : pc_update_unit_pkg
// Brief    : Shared CPU definitions for the fetch-side PC update logic.
// Revision : 1.0
// ============================================================================
`default_nettype none

package pc_update_unit_pkg;

    localparam logic [1:0] c_ST_RUN   = 2'd0;
    localparam logic [1:0] c_ST_WAIT  = 2'd1;
    localparam logic [1:0] c_ST_HALT  = 2'd2;
    localparam logic [1:0] c_ST_FAULT = 2'd3;

    localparam logic [1:0] c_PCSRC_SEQ    = 2'b00;
    localparam logic [1:0] c_PCSRC_BRANCH = 2'b01;
    localparam logic [1:0] c_PCSRC_JUMP   = 2'b10;
    localparam logic [1:0] c_PCSRC_REG    = 2'b11;

endpackage

`default_nettype wire

// File: rtl/pc_next_mux.sv
// ============================================================================
// Module   : pc_next_mux
// Brief    : Combinational next-PC selector; an untaken branch falls through.
// Revision : 1.0
// ============================================================================
`default_nettype none

module pc_next_mux
    import pc_update_unit_pkg::*;
(
    input  logic [31:0] PCPlus4,
    input  logic [31:0] branchPC,
    input  logic [31:0] jmpPC,
    input  logic [31:0] regPC,
    input  logic [1:0]  PCSrc,
    input  logic        branchTaken,
    output logic [31:0] nextPC
);

    always_comb begin
        nextPC = PCPlus4;
        case (PCSrc)
            c_PCSRC_SEQ:    nextPC = PCPlus4;
            c_PCSRC_BRANCH: nextPC = branchTaken ? branchPC : PCPlus4;
            c_PCSRC_JUMP:   nextPC = jmpPC;
            c_PCSRC_REG:    nextPC = regPC;
            default:        nextPC = PCPlus4;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/pc_update_unit.sv
// ============================================================================
// Module   : pc_update_unit
// Brief    : PC register plus RUN/WAIT/HALT/FAULT fetch control FSM.
// Revision : 1.0
// ============================================================================
`default_nettype none

module pc_update_unit
    import pc_update_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [31:0] PCPlus4,
    input  logic [31:0] branchPC,
    input  logic [31:0] jmpPC,
    input  logic [31:0] regPC,
    input  logic [1:0]  PCSrc,
    input  logic        branchTaken,
    input  logic        PCWrite,
    input  logic        halt,
    input  logic        imemReady,
    output logic [31:0] curPC,
    output logic        fetchValid,
    output logic        halted,
    output logic        misaligned
);

    logic [1:0]  r_state;
    logic [1:0]  w_state_next;
    logic [31:0] r_pc;
    logic [31:0] w_pc_next;
    logic [31:0] w_target;

    pc_next_mux u_next_mux (
        .PCPlus4     (PCPlus4),
        .branchPC    (branchPC),
        .jmpPC       (jmpPC),
        .regPC       (regPC),
        .PCSrc       (PCSrc),
        .branchTaken (branchTaken),
        .nextPC      (w_target)
    );

    always_ff @(posedge CLK) begin
        if (!RST) begin
            r_state <= c_ST_RUN;
            r_pc    <= RESET_PC;
        end else begin
            r_state <= w_state_next;
            r_pc    <= w_pc_next;
        end
    end

    // Priority: halt, then stall, then memory back-pressure, then alignment.
    always_comb begin
        w_state_next = r_state;
        w_pc_next    = r_pc;
        case (r_state)
            c_ST_RUN, c_ST_WAIT: begin
                if (halt) begin
                    w_state_next = c_ST_HALT;
                end else if (!PCWrite) begin
                    w_state_next = r_state;
                end else if (!imemReady) begin
                    w_state_next = c_ST_WAIT;
                end else if (w_target[1:0] != 2'b00) begin
                    w_state_next = c_ST_FAULT;
                end else begin
                    w_state_next = c_ST_RUN;
                    w_pc_next    = w_target;
                end
            end
            default: begin
                w_state_next = r_state;
            end
        endcase
    end

    assign curPC      = r_pc;
    assign fetchValid = (r_state == c_ST_RUN) || (r_state == c_ST_WAIT);
    assign halted     = (r_state == c_ST_HALT);
    assign misaligned = (r_state == c_ST_FAULT);

endmodule

`default_nettype wire

// File: tb/tb_pc_update_unit.sv
// ============================================================================
// Module   : tb_pc_update_unit
// Brief    : Directed and randomized checks of pc_update_unit against a model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_pc_update_unit;

    localparam logic [31:0] c_RESET_PC = 32'h0000_0000;
    localparam int c_M_RUN   = 0;
    localparam int c_M_WAIT  = 1;
    localparam int c_M_HALT  = 2;
    localparam int c_M_FAULT = 3;

    logic        clk;
    logic        RST;
    logic [31:0] PCPlus4, branchPC, jmpPC, regPC;
    logic [1:0]  PCSrc;
    logic        branchTaken, PCWrite, halt, imemReady;
    logic [31:0] curPC;
    logic        fetchValid, halted, misaligned;

    int          n_checks = 0;
    int          n_errors = 0;

    logic [31:0] m_pc;
    int          m_mode;
    bit          m_valid = 1'b0;

    pc_update_unit #(.RESET_PC(c_RESET_PC)) dut (
        .CLK         (clk),
        .RST         (RST),
        .PCPlus4     (PCPlus4),
        .branchPC    (branchPC),
        .jmpPC       (jmpPC),
        .regPC       (regPC),
        .PCSrc       (PCSrc),
        .branchTaken (branchTaken),
        .PCWrite     (PCWrite),
        .halt        (halt),
        .imemReady   (imemReady),
        .curPC       (curPC),
        .fetchValid  (fetchValid),
        .halted      (halted),
        .misaligned  (misaligned)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: what the PC and mode must be after each edge.
    always @(posedge clk) begin
        logic [31:0] tgt;
        if (!RST) begin
            m_pc    = c_RESET_PC;
            m_mode  = c_M_RUN;
            m_valid = 1'b1;
        end else if (m_valid && (m_mode == c_M_RUN || m_mode == c_M_WAIT)) begin
            if (PCSrc == 2'd1 && branchTaken) tgt = branchPC;
            else if (PCSrc == 2'd2)           tgt = jmpPC;
            else if (PCSrc == 2'd3)           tgt = regPC;
            else                              tgt = PCPlus4;
            if (halt)                  m_mode = c_M_HALT;
            else if (!PCWrite)         m_mode = m_mode;
            else if (!imemReady)       m_mode = c_M_WAIT;
            else if (tgt % 4 != 0)     m_mode = c_M_FAULT;
            else begin
                m_pc   = tgt;
                m_mode = c_M_RUN;
            end
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            chk("model_curPC", curPC, m_pc);
            chk("model_fetchValid", {31'd0, fetchValid},
                {31'd0, (m_mode == c_M_RUN || m_mode == c_M_WAIT)});
            chk("model_halted", {31'd0, halted}, {31'd0, (m_mode == c_M_HALT)});
            chk("model_misaligned", {31'd0, misaligned}, {31'd0, (m_mode == c_M_FAULT)});
        end
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic set_seq();
        RST         = 1'b1;
        PCSrc       = 2'b00;
        PCPlus4     = m_pc + 32'd4;
        branchTaken = 1'b0;
        PCWrite     = 1'b1;
        imemReady   = 1'b1;
        halt        = 1'b0;
    endtask

    task automatic jump_to(input logic [31:0] addr);
        set_seq();
        PCSrc = 2'b10;
        jmpPC = addr;
        cyc();
    endtask

    function automatic logic [31:0] rnd_addr();
        logic [31:0] a;
        a = $urandom;
        a[1:0] = ($urandom_range(0, 19) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
        return a;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        RST = 1'b0; PCPlus4 = '0; branchPC = '0; jmpPC = '0; regPC = '0;
        PCSrc = 2'b00; branchTaken = 1'b0; PCWrite = 1'b1; halt = 1'b0; imemReady = 1'b1;
        cyc();
        chk("reset_curPC", curPC, 32'h0);
        chk("reset_fetchValid", {31'd0, fetchValid}, 32'd1);
        chk("reset_halted", {31'd0, halted}, 32'd0);
        chk("reset_misaligned", {31'd0, misaligned}, 32'd0);

        set_seq(); cyc(); chk("seq_pc4", curPC, 32'h4);
        set_seq(); cyc(); chk("seq_pc8", curPC, 32'h8);

        jump_to(32'h10); chk("jump_0x10", curPC, 32'h10);
        set_seq(); PCSrc = 2'b01; branchPC = 32'h40; branchTaken = 1'b0; cyc();
        chk("branch_not_taken", curPC, 32'h14);
        jump_to(32'h10);
        set_seq(); PCSrc = 2'b01; branchPC = 32'h40; branchTaken = 1'b1; cyc();
        chk("branch_taken", curPC, 32'h40);

        jump_to(32'h20);
        set_seq(); imemReady = 1'b0; repeat (3) cyc();
        chk("wait_hold_pc", curPC, 32'h20);
        chk("wait_fetchValid", {31'd0, fetchValid}, 32'd1);
        set_seq(); cyc(); chk("wait_resume", curPC, 32'h24);
        jump_to(32'h20);
        set_seq(); PCWrite = 1'b0; imemReady = 1'b0; cyc();
        imemReady = 1'b1; repeat (2) cyc();
        chk("stall_hold_pc", curPC, 32'h20);
        set_seq(); cyc(); chk("stall_resume", curPC, 32'h24);

        set_seq(); halt = 1'b1; PCSrc = 2'b10; jmpPC = 32'h80; cyc();
        chk("halt_halted", {31'd0, halted}, 32'd1);
        chk("halt_pc_not_jump", {31'd0, (curPC != 32'h80)}, 32'd1);
        set_seq(); cyc();
        chk("halt_sticky", {31'd0, halted}, 32'd1);
        RST = 1'b0; cyc();
        chk("halt_reset_pc", curPC, c_RESET_PC);
        chk("halt_reset_halted", {31'd0, halted}, 32'd0);

        jump_to(32'hFFFF_FFFC);
        set_seq(); cyc();
        chk("wrap_pc", curPC, 32'h0);
        chk("wrap_no_fault", {31'd0, misaligned}, 32'd0);

        set_seq(); PCSrc = 2'b11; regPC = 32'h102; imemReady = 1'b0; cyc();
        chk("misalign_gated_by_ready", {31'd0, misaligned}, 32'd0);
        imemReady = 1'b1; cyc();
        chk("misalign_flag", {31'd0, misaligned}, 32'd1);
        chk("misalign_pc_hold", curPC, 32'h0);
        chk("misalign_fetchValid", {31'd0, fetchValid}, 32'd0);
        set_seq(); repeat (3) cyc();
        chk("misalign_sticky", {31'd0, misaligned}, 32'd1);
        RST = 1'b0; cyc();
        chk("misalign_reset", {31'd0, misaligned}, 32'd0);

        for (int i = 0; i < 500; i++) begin
            RST         = ($urandom_range(0, 39) != 0);
            halt        = ($urandom_range(0, 49) == 0);
            PCWrite     = ($urandom_range(0, 4) != 0);
            imemReady   = ($urandom_range(0, 3) != 0);
            PCSrc       = 2'($urandom_range(0, 3));
            branchTaken = 1'($urandom_range(0, 1));
            PCPlus4     = ($urandom_range(0, 9) != 0) ? m_pc + 32'd4 : rnd_addr();
            branchPC    = rnd_addr();
            jmpPC       = rnd_addr();
            regPC       = rnd_addr();
            cyc();
        end

        @(negedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
